// File: rtl/sc_collatzseq_pkg.sv
// sc_collatzseq_pkg: state set, uDATAPATH control encodings and error codes
// shared by the Collatz sequencer and its control-word decoder.
package sc_collatzseq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_CHK1,
        S_CHKPAR,
        S_SHLD,
        S_SHR,
        S_SHWB,
        S_ADD1,
        S_ADD2,
        S_INC,
        S_ERROR,
        S_DONE
    } state_e;

    localparam logic [2:0] DEC_NONE = 3'b000;
    localparam logic [2:0] DEC_R0   = 3'b001;
    localparam logic [2:0] DEC_R1   = 3'b010;

    localparam logic [2:0] MUX_R0      = 3'b000;
    localparam logic [2:0] MUX_R1      = 3'b001;
    localparam logic [2:0] MUX_INPUT   = 3'b100;
    localparam logic [2:0] MUX_ZERO    = 3'b101;
    localparam logic [2:0] MUX_SHIFTER = 3'b110;

    localparam logic [3:0] ALU_PASSA  = 4'b0000;
    localparam logic [3:0] ALU_ADD    = 4'b0001;
    localparam logic [3:0] ALU_INCA   = 4'b0010;
    localparam logic [3:0] ALU_DECA   = 4'b0011;
    localparam logic [3:0] ALU_ANDONE = 4'b0100;

    localparam logic [1:0] SH_HOLD = 2'b00;
    localparam logic [1:0] SH_SHR  = 2'b01;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ZERO  = 2'b01;
    localparam logic [1:0] ERR_OVF   = 2'b10;
    localparam logic [1:0] ERR_LIMIT = 2'b11;

    typedef struct packed {
        logic [2:0] dec_clr;
        logic [2:0] dec_ld;
        logic [2:0] mux_a;
        logic [2:0] mux_b;
        logic [3:0] alu;
        logic       sh_clr_n;
        logic       sh_ld_n;
        logic [1:0] sh_sel;
    } ucode_t;

    localparam ucode_t UC_NOP = '{
        dec_clr:  DEC_NONE,
        dec_ld:   DEC_NONE,
        mux_a:    MUX_R0,
        mux_b:    MUX_R0,
        alu:      ALU_PASSA,
        sh_clr_n: 1'b1,
        sh_ld_n:  1'b1,
        sh_sel:   SH_HOLD
    };

endpackage

// File: rtl/sc_collatzseq_ucode.sv
// sc_collatzseq_ucode: combinational state-to-control-word decoder
// for the uDATAPATH bus driven by the Collatz sequencer.
module sc_collatzseq_ucode
    import sc_collatzseq_pkg::*;
(
    input  state_e state_i,
    output ucode_t ucode_o
);

    always_comb begin
        ucode_o = UC_NOP;
        unique case (state_i)
            S_LOAD: begin
                ucode_o.mux_a  = MUX_INPUT;
                ucode_o.alu    = ALU_PASSA;
                ucode_o.dec_ld = DEC_R0;
            end
            S_CHK1: begin
                ucode_o.mux_a = MUX_R0;
                ucode_o.alu   = ALU_DECA;
            end
            S_CHKPAR: begin
                ucode_o.mux_a = MUX_R0;
                ucode_o.alu   = ALU_ANDONE;
            end
            S_SHLD: begin
                ucode_o.mux_a   = MUX_R0;
                ucode_o.alu     = ALU_PASSA;
                ucode_o.sh_ld_n = 1'b0;
            end
            S_SHR: begin
                ucode_o.sh_sel = SH_SHR;
            end
            S_SHWB: begin
                ucode_o.mux_a  = MUX_SHIFTER;
                ucode_o.alu    = ALU_PASSA;
                ucode_o.dec_ld = DEC_R0;
            end
            // 2n then 3n accumulate in R1 so R0 still holds n for ADD2
            S_ADD1: begin
                ucode_o.mux_a  = MUX_R0;
                ucode_o.mux_b  = MUX_R0;
                ucode_o.alu    = ALU_ADD;
                ucode_o.dec_ld = DEC_R1;
            end
            S_ADD2: begin
                ucode_o.mux_a  = MUX_R1;
                ucode_o.mux_b  = MUX_R0;
                ucode_o.alu    = ALU_ADD;
                ucode_o.dec_ld = DEC_R1;
            end
            S_INC: begin
                ucode_o.mux_a  = MUX_R1;
                ucode_o.alu    = ALU_INCA;
                ucode_o.dec_ld = DEC_R0;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/sc_collatzseq.sv
// sc_collatzseq: microcoded Collatz stopping-time sequencer for uDATAPATH.
// Define COLLATZ_STEPLIMIT_EN to abort with error 11 once MAX_STEPS is reached.
module sc_collatzseq
    import sc_collatzseq_pkg::*;
#(
    parameter int DATAWIDTH_DECODER_SELECTION    = 3,
    parameter int DATAWIDTH_MUX_SELECTION        = 3,
    parameter int DATAWIDTH_ALU_SELECTION        = 4,
    parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2,
    parameter int MAX_STEPS                      = 200
) (
    input  logic                                      SC_COLLATZSEQ_CLOCK_50,
    input  logic                                      SC_COLLATZSEQ_RESET_InLow,
    input  logic                                      SC_COLLATZSEQ_start_InHigh,
    input  logic                                      SC_COLLATZSEQ_overflow_InLow,
    input  logic                                      SC_COLLATZSEQ_carry_InLow,
    input  logic                                      SC_COLLATZSEQ_negative_InLow,
    input  logic                                      SC_COLLATZSEQ_zero_InLow,
    output logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_COLLATZSEQ_decoderclearselection_OutBUS,
    output logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_COLLATZSEQ_decoderloadselection_OutBUS,
    output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_COLLATZSEQ_muxselectionBUSA_OutBUS,
    output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_COLLATZSEQ_muxselectionBUSB_OutBUS,
    output logic [DATAWIDTH_ALU_SELECTION-1:0]        SC_COLLATZSEQ_aluselection_OutBUS,
    output logic                                      SC_COLLATZSEQ_regSHIFTERclear_OutLow,
    output logic                                      SC_COLLATZSEQ_regSHIFTERload_OutLow,
    output logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_COLLATZSEQ_regSHIFTERshiftselection_OutLow,
    output logic                                      SC_COLLATZSEQ_busy_OutHigh,
    output logic                                      SC_COLLATZSEQ_done_OutHigh,
    output logic [7:0]                                SC_COLLATZSEQ_stepcount_OutBUS,
    output logic [1:0]                                SC_COLLATZSEQ_error_OutBUS
);

    state_e     state_q, state_d;
    logic [7:0] step_q, step_d;
    logic [1:0] err_q, err_d;
    logic [7:0] step_inc;
    logic       zero, arith_fault;
    logic       unused_negative;
    ucode_t     uc;

`ifdef COLLATZ_STEPLIMIT_EN
    localparam logic [7:0] STEP_LIMIT = 8'(MAX_STEPS);
`else
    logic [7:0] unused_max_steps;
    assign unused_max_steps = 8'(MAX_STEPS);
`endif

    assign zero            = ~SC_COLLATZSEQ_zero_InLow;
    assign arith_fault     = ~SC_COLLATZSEQ_carry_InLow | ~SC_COLLATZSEQ_overflow_InLow;
    assign unused_negative = SC_COLLATZSEQ_negative_InLow;
    assign step_inc        = (step_q == 8'hFF) ? step_q : step_q + 8'd1;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (SC_COLLATZSEQ_start_InHigh) begin
                    state_d = S_LOAD;
                    step_d  = '0;
                    err_d   = ERR_OK;
                end
            end
            S_LOAD: begin
                if (zero) begin
                    state_d = S_ERROR;
                    err_d   = ERR_ZERO;
                end else begin
                    state_d = S_CHK1;
                end
            end
            S_CHK1: begin
                if (zero) begin
                    state_d = S_DONE;
`ifdef COLLATZ_STEPLIMIT_EN
                end else if (step_q == STEP_LIMIT) begin
                    state_d = S_ERROR;
                    err_d   = ERR_LIMIT;
`endif
                end else begin
                    state_d = S_CHKPAR;
                end
            end
            S_CHKPAR: state_d = zero ? S_SHLD : S_ADD1;
            S_SHLD:   state_d = S_SHR;
            S_SHR:    state_d = S_SHWB;
            S_SHWB: begin
                state_d = S_CHK1;
                step_d  = step_inc;
            end
            S_ADD1, S_ADD2, S_INC: begin
                if (arith_fault) begin
                    state_d = S_ERROR;
                    err_d   = ERR_OVF;
                end else if (state_q == S_ADD1) begin
                    state_d = S_ADD2;
                end else if (state_q == S_ADD2) begin
                    state_d = S_INC;
                end else begin
                    state_d = S_CHK1;
                    step_d  = step_inc;
                end
            end
            S_ERROR, S_DONE: state_d = S_IDLE;
            default:         state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge SC_COLLATZSEQ_CLOCK_50 or negedge SC_COLLATZSEQ_RESET_InLow) begin
        if (!SC_COLLATZSEQ_RESET_InLow) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            err_q   <= ERR_OK;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            err_q   <= err_d;
        end
    end

    sc_collatzseq_ucode u_ucode (
        .state_i (state_q),
        .ucode_o (uc)
    );

    assign SC_COLLATZSEQ_decoderclearselection_OutBUS    = DATAWIDTH_DECODER_SELECTION'(uc.dec_clr);
    assign SC_COLLATZSEQ_decoderloadselection_OutBUS     = DATAWIDTH_DECODER_SELECTION'(uc.dec_ld);
    assign SC_COLLATZSEQ_muxselectionBUSA_OutBUS         = DATAWIDTH_MUX_SELECTION'(uc.mux_a);
    assign SC_COLLATZSEQ_muxselectionBUSB_OutBUS         = DATAWIDTH_MUX_SELECTION'(uc.mux_b);
    assign SC_COLLATZSEQ_aluselection_OutBUS             = DATAWIDTH_ALU_SELECTION'(uc.alu);
    assign SC_COLLATZSEQ_regSHIFTERclear_OutLow          = uc.sh_clr_n;
    assign SC_COLLATZSEQ_regSHIFTERload_OutLow           = uc.sh_ld_n;
    assign SC_COLLATZSEQ_regSHIFTERshiftselection_OutLow = DATAWIDTH_REGSHIFTER_SELECTION'(uc.sh_sel);

    assign SC_COLLATZSEQ_busy_OutHigh     = (state_q != S_IDLE);
    assign SC_COLLATZSEQ_done_OutHigh     = (state_q == S_DONE) || (state_q == S_ERROR);
    assign SC_COLLATZSEQ_stepcount_OutBUS = step_q;
    assign SC_COLLATZSEQ_error_OutBUS     = err_q;

endmodule

// File: tb/tb_sc_collatzseq.sv
// tb_sc_collatzseq: sequencer driving a behavioural 8-bit uDATAPATH,
// results compared with an arithmetic Collatz reference.
module tb_sc_collatzseq;

`ifdef COLLATZ_STEPLIMIT_EN
    localparam int MAXS = 10;
`else
    localparam int MAXS = 200;
`endif
    localparam int TMO = 2000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       ovf_n, carry_n, neg_n, zero_n;
    logic [2:0] dclr, dld, mxa, mxb;
    logic [3:0] alu;
    logic       shclr_n, shld_n;
    logic [1:0] shsel;
    logic       busy, done;
    logic [7:0] steps;
    logic [1:0] err;

    logic [7:0] din = 8'd0;
    logic [7:0] r0, r1, shreg, bus_a, bus_b, y;
    logic       cy, ov;

    int n_cmp = 0;
    int n_bad = 0;

    always #10 clk = ~clk;

    sc_collatzseq #(.MAX_STEPS(MAXS)) dut (
        .SC_COLLATZSEQ_CLOCK_50                        (clk),
        .SC_COLLATZSEQ_RESET_InLow                     (rst_n),
        .SC_COLLATZSEQ_start_InHigh                    (start),
        .SC_COLLATZSEQ_overflow_InLow                  (ovf_n),
        .SC_COLLATZSEQ_carry_InLow                     (carry_n),
        .SC_COLLATZSEQ_negative_InLow                  (neg_n),
        .SC_COLLATZSEQ_zero_InLow                      (zero_n),
        .SC_COLLATZSEQ_decoderclearselection_OutBUS    (dclr),
        .SC_COLLATZSEQ_decoderloadselection_OutBUS     (dld),
        .SC_COLLATZSEQ_muxselectionBUSA_OutBUS         (mxa),
        .SC_COLLATZSEQ_muxselectionBUSB_OutBUS         (mxb),
        .SC_COLLATZSEQ_aluselection_OutBUS             (alu),
        .SC_COLLATZSEQ_regSHIFTERclear_OutLow          (shclr_n),
        .SC_COLLATZSEQ_regSHIFTERload_OutLow           (shld_n),
        .SC_COLLATZSEQ_regSHIFTERshiftselection_OutLow (shsel),
        .SC_COLLATZSEQ_busy_OutHigh                    (busy),
        .SC_COLLATZSEQ_done_OutHigh                    (done),
        .SC_COLLATZSEQ_stepcount_OutBUS                (steps),
        .SC_COLLATZSEQ_error_OutBUS                    (err)
    );

    // Behavioural datapath: two registers, a shifter, muxes and an ALU
    always_comb begin
        case (mxa)
            3'b000:  bus_a = r0;
            3'b001:  bus_a = r1;
            3'b100:  bus_a = din;
            3'b110:  bus_a = shreg;
            default: bus_a = 8'd0;
        endcase
        case (mxb)
            3'b000:  bus_b = r0;
            3'b001:  bus_b = r1;
            3'b100:  bus_b = din;
            3'b110:  bus_b = shreg;
            default: bus_b = 8'd0;
        endcase
        y  = 8'd0;
        cy = 1'b0;
        ov = 1'b0;
        case (alu)
            4'b0000: y = bus_a;
            4'b0001: begin
                {cy, y} = {1'b0, bus_a} + {1'b0, bus_b};
                ov = (bus_a[7] == bus_b[7]) && (y[7] != bus_a[7]);
            end
            4'b0010: begin
                {cy, y} = {1'b0, bus_a} + 9'd1;
                ov = (bus_a == 8'h7F);
            end
            4'b0011: y = bus_a - 8'd1;
            4'b0100: y = bus_a & 8'd1;
            default: y = 8'd0;
        endcase
        zero_n  = (y != 8'd0);
        carry_n = ~cy;
        ovf_n   = ~ov;
        neg_n   = ~y[7];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0    <= 8'd0;
            r1    <= 8'd0;
            shreg <= 8'd0;
        end else begin
            if (dclr == 3'b001) r0 <= 8'd0;
            if (dclr == 3'b010) r1 <= 8'd0;
            if (dld == 3'b001) r0 <= y;
            if (dld == 3'b010) r1 <= y;
            if (!shclr_n) shreg <= 8'd0;
            else if (!shld_n) shreg <= y;
            else if (shsel == 2'b01) shreg <= shreg >> 1;
        end
    end

    function automatic int sgn8(input int a);
        return (a > 127) ? a - 256 : a;
    endfunction

    function automatic bit bad_add(input int a, input int b);
        int s;
        s = sgn8(a) + sgn8(b);
        return (a + b > 255) || (s > 127) || (s < -128);
    endfunction

    // Collatz walk on an 8-bit machine: steps, error code, start-to-done cycles
    function automatic void ref_collatz(input int n, output int rs,
                                        output int re, output int rc);
        int m;
        m  = n;
        rs = 0;
        re = 0;
        rc = 0;
        if (m == 0) begin
            re = 1;
            rc = 2;
            return;
        end
        for (int guard = 0; guard < 1000; guard++) begin
            if (m == 1) begin
                rc = 3 + 5 * rs;
                return;
            end
`ifdef COLLATZ_STEPLIMIT_EN
            if (rs == MAXS) begin
                re = 3;
                rc = 3 + 5 * rs;
                return;
            end
`endif
            if (m % 2 == 0) begin
                m = m / 2;
            end else begin
                if (bad_add(m, m)) begin
                    re = 2;
                    rc = 5 + 5 * rs;
                    return;
                end
                if (bad_add(2 * m, m)) begin
                    re = 2;
                    rc = 6 + 5 * rs;
                    return;
                end
                if (3 * m + 1 > 255 || 3 * m == 127) begin
                    re = 2;
                    rc = 7 + 5 * rs;
                    return;
                end
                m = 3 * m + 1;
            end
            if (rs < 255) rs++;
        end
    endfunction

    // Caller is at a negedge with the DUT idle; returns at the done negedge
    task automatic run_one(input logic [7:0] n, output int cyc);
        din   = n;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < TMO) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        if (!done) cyc = -1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #4;
        n_cmp++;
        if ({busy, done, steps, err} !== 12'd0) begin
            n_bad++;
            $display("FAIL reset_status: got %h required 000", {busy, done, steps, err});
        end
        n_cmp++;
        if ({dclr, dld, mxa, mxb, alu, shsel} !== 18'd0 || {shclr_n, shld_n} !== 2'b11) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %h/%b required 0/11",
                     {dclr, dld, mxa, mxb, alu, shsel}, {shclr_n, shld_n});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        int tn[6];
        int ts[6];
        int te[6];
        int tc[6];
        int cyc;
        tn = '{1, 6, 0, 255, 27, 7};
        ts = '{0, 8, 0, 0, 7, 16};
        te = '{0, 0, 1, 2, 2, 0};
        tc = '{3, 43, 2, 5, 41, 83};
`ifdef COLLATZ_STEPLIMIT_EN
        ts[5] = 10;
        te[5] = 3;
        tc[5] = 53;
`endif
        for (int i = 0; i < 6; i++) begin
            run_one(8'(tn[i]), cyc);
            n_cmp++;
            if (cyc != tc[i]) begin
                n_bad++;
                $display("FAIL dir_latency n=%0d: got %0d required %0d", tn[i], cyc, tc[i]);
            end
            n_cmp++;
            if (steps !== 8'(ts[i])) begin
                n_bad++;
                $display("FAIL dir_steps n=%0d: got %0d required %0d", tn[i], steps, ts[i]);
            end
            n_cmp++;
            if (err !== 2'(te[i])) begin
                n_bad++;
                $display("FAIL dir_error n=%0d: got %0d required %0d", tn[i], err, te[i]);
            end
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL dir_pulse n=%0d: got done=%b busy=%b required 0 0", tn[i], done, busy);
            end
        end
    endtask

    task automatic test_random();
        int n, rs, re, rc, cyc;
        for (int i = 0; i < 40; i++) begin
            n = (i % 8 == 0) ? 0 : int'($urandom_range(1, 255));
            ref_collatz(n, rs, re, rc);
            run_one(8'(n), cyc);
            n_cmp++;
            if (cyc != rc || steps !== 8'(rs) || err !== 2'(re)) begin
                n_bad++;
                $display("FAIL rnd n=%0d: got cyc=%0d st=%0d err=%0d required %0d %0d %0d",
                         n, cyc, steps, err, rc, rs, re);
            end
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0) begin
                n_bad++;
                $display("FAIL rnd_pulse n=%0d: got done=%b required 0", n, done);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n2, rs, re, rc, cyc, gap;
        n2 = int'($urandom_range(2, 60));
        ref_collatz(n2, rs, re, rc);
        din   = 8'd1;
        start = 1'b1;
        cyc   = 0;
        while (!done && cyc < TMO) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        n_cmp++;
        if (cyc != 3) begin
            n_bad++;
            $display("FAIL b2b_first: got %0d required 3", cyc);
        end
        din = 8'(n2);
        gap = 0;
        do begin
            @(posedge clk);
            gap++;
            @(negedge clk);
            if (gap == 2) start = 1'b0;
        end while (!done && gap < TMO);
        start = 1'b0;
        n_cmp++;
        if (gap != rc + 1) begin
            n_bad++;
            $display("FAIL b2b_gap n=%0d: got %0d required %0d", n2, gap, rc + 1);
        end
        n_cmp++;
        if (steps !== 8'(rs) || err !== 2'(re)) begin
            n_bad++;
            $display("FAIL b2b_result n=%0d: got %0d/%0d required %0d/%0d", n2, steps, err, rs, re);
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_idle: got busy=%b required 0", busy);
        end
    endtask

    task automatic test_start_while_busy();
        int rs, re, rc, cyc, off;
        ref_collatz(6, rs, re, rc);
        off   = int'($urandom_range(4, 30));
        din   = 8'd6;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < TMO) begin
            if (cyc == off) begin
                din   = 8'd0;
                start = 1'b1;
            end
            if (cyc == off + 3) start = 1'b0;
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        n_cmp++;
        if (cyc != rc || steps !== 8'(rs) || err !== 2'(re)) begin
            n_bad++;
            $display("FAIL busy_start: got cyc=%0d st=%0d err=%0d required %0d %0d %0d",
                     cyc, steps, err, rc, rs, re);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        int seen;
        din   = 8'd7;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || steps === 8'd0) begin
            n_bad++;
            $display("FAIL mid_running: got busy=%b steps=%0d required 1 and nonzero", busy, steps);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, steps, err} !== 12'd0 ||
            {dclr, dld, mxa, mxb, alu, shsel} !== 18'd0 || {shclr_n, shld_n} !== 2'b11) begin
            n_bad++;
            $display("FAIL mid_reset: got %h/%h/%b required 000/0/11",
                     {busy, done, steps, err}, {dclr, dld, mxa, mxb, alu, shsel}, {shclr_n, shld_n});
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL mid_nodone: got %0d active cycles required 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_start_while_busy();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
